// File: rtl/ram_port_arbiter_pkg.sv
// Shared defaults and types for the dual-port RAM arbiter.
package ram_arb_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 64;
  localparam int ADDR_W_DEF  = 12;
  localparam int RD_LAT_DEF  = 1;

  typedef logic [ADDR_W_DEF-1:0] ram_addr_t;
  typedef logic [DATA_W_DEF-1:0] ram_data_t;

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 == n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; pointer moves past the winner on accept.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N = NUM_REQ_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         hold,
  output logic [N-1:0] cand,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] win;
  logic          found;

  always_comb begin
    cand  = '0;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        cand[idx] = 1'b1;
        win       = idx;
        found     = 1'b1;
      end
    end
  end

  // hold suppresses the grant without disturbing the rotation
  assign gnt = hold ? '0 : cand;

  always_ff @(posedge clock) begin
    if (reset)
      ptr <= '0;
    else if (found && !hold)
      ptr <= PW'(wrap_inc(int'(win), N));
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a dual-port RAM among NUM_REQ requesters with independent round-robin write/read arbitration.
// Optional RAM_ARB_COLLISION_EN: stall a read that hits the address being written in the same cycle.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int RD_LAT  = RD_LAT_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        wr_req_valid,
  output logic [NUM_REQ-1:0]        wr_req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] wr_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] wr_req_data,
  input  logic [NUM_REQ-1:0]        rd_req_valid,
  output logic [NUM_REQ-1:0]        rd_req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] rd_req_addr,
  output logic [NUM_REQ-1:0]        rd_rsp_valid,
  output logic [DATA_W-1:0]         rd_rsp_data,
  output logic                      write,
  output logic [ADDR_W-1:0]         wr_address,
  output logic [DATA_W-1:0]         data_in,
  output logic                      read,
  output logic [ADDR_W-1:0]         rd_address,
  input  logic [DATA_W-1:0]         data_out
);
  logic [NUM_REQ-1:0] wr_cand, wr_gnt, rd_cand, rd_gnt;
  logic [ADDR_W-1:0]  wr_sel_addr, rd_sel_addr;
  logic [DATA_W-1:0]  wr_sel_data;
  logic               collide;
  logic [RD_LAT:0][NUM_REQ-1:0] tag_pipe;

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clock(clock), .reset(reset), .req(wr_req_valid), .hold(reset),
    .cand(wr_cand), .gnt(wr_gnt)
  );

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clock(clock), .reset(reset), .req(rd_req_valid), .hold(reset | collide),
    .cand(rd_cand), .gnt(rd_gnt)
  );

  always_comb begin
    wr_sel_addr = '0;
    wr_sel_data = '0;
    rd_sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_gnt[i]) begin
        wr_sel_addr = wr_req_addr[i*ADDR_W +: ADDR_W];
        wr_sel_data = wr_req_data[i*DATA_W +: DATA_W];
      end
      if (rd_cand[i]) rd_sel_addr = rd_req_addr[i*ADDR_W +: ADDR_W];
    end
  end

`ifdef RAM_ARB_COLLISION_EN
  // compare against the un-held read candidate to avoid a loop through the read grant
  assign collide = (|wr_gnt) && (|rd_cand) && (wr_sel_addr == rd_sel_addr);
`else
  assign collide = 1'b0;
`endif

  assign wr_req_ready = wr_gnt;
  assign rd_req_ready = rd_gnt;
  assign rd_rsp_valid = tag_pipe[RD_LAT];
  assign rd_rsp_data  = (|tag_pipe[RD_LAT]) ? data_out : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      write      <= 1'b0;
      wr_address <= '0;
      data_in    <= '0;
      read       <= 1'b0;
      rd_address <= '0;
      tag_pipe   <= '0;
    end else begin
      write <= |wr_gnt;
      if (|wr_gnt) begin
        wr_address <= wr_sel_addr;
        data_in    <= wr_sel_data;
      end
      read <= |rd_gnt;
      if (|rd_gnt) rd_address <= rd_sel_addr;
      tag_pipe[0] <= rd_gnt;
      for (int s = 1; s <= RD_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  // wr_cand is only needed by the collision compare through wr_gnt
  logic unused_ok;
  assign unused_ok = ^wr_cand;
endmodule
